// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared FSM states, bank decode and response type for mem_port_master
package mem_port_pkg;
  localparam int RSP_DATA_W = 12;
  typedef enum logic [1:0] {ACTIVE = 2'd0, DRAIN = 2'd1, IDLE = 2'd2} state_e;
  typedef struct packed {
    logic [1:0]            bank;
    logic [RSP_DATA_W-1:0] data;
  } rsp_t;
  function automatic logic [1:0] bank_of(input logic [31:0] addr, input int unsigned aw);
    return addr[aw-1 -: 2];
  endfunction
endpackage

// File: rtl/mem_port_master_if.sv
// mem_port_master_if: client command/response, memory port and control signals of one port master
interface mem_port_master_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic [1:0]        o_rsp_bank;
  logic              o_wr_done;
  logic              i_flush;
  logic              o_idle;
  modport master (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_mem_rdata, i_rsp_ready, i_flush,
    output o_req_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_rsp_valid, o_rsp_data,
           o_rsp_bank, o_wr_done, o_idle
  );
  modport slave (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_mem_rdata, i_rsp_ready, i_flush,
    input  o_req_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_rsp_valid, o_rsp_data,
           o_rsp_bank, o_wr_done, o_idle
  );
endinterface

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: synchronous show-ahead FIFO with occupancy count
module mem_rsp_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_o <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= din_i;
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i) rp_q <= rp_q + AW'(1);
      count_o <= count_o + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign dout_o = mem_q[rp_q];
endmodule

// File: rtl/mem_port_master.sv
// mem_port_master: drives one memory port, tracks reads, buffers responses; MPM_PERF_CNT_EN adds perf counters
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_master_if.master bus
`ifdef MPM_PERF_CNT_EN
  ,
  output logic [15:0] o_rd_cnt,
  output logic [15:0] o_wr_cnt,
  output logic [15:0] o_stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_ACTIVE = ACTIVE;
  localparam logic [1:0] S_DRAIN  = DRAIN;
  localparam logic [1:0] S_IDLE   = IDLE;
  logic [1:0]        state_q, state_d;
  logic              alive_q, idle_q, wr_done_q, mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [RD_LATENCY-1:0] rv_q;
  logic [1:0]        rb_q [RD_LATENCY];
  logic [WR_LATENCY:0] wv_q;
  logic [ADDR_W-1:0] wa_q [WR_LATENCY+1];
  logic [CW:0]       count;
  logic [DATA_W+1:0] fifo_dout;
  logic [15:0]       occ;
  logic              hazard, drained, acc, pop;
  // occupancy = buffered responses plus every read not yet pushed
  always_comb begin
    occ = 16'(count) + 16'(mem_en_q & ~mem_we_q);
    for (int i = 0; i < RD_LATENCY; i++) occ = occ + 16'(rv_q[i]);
    hazard = 1'b0;
    for (int i = 0; i <= WR_LATENCY; i++)
      hazard = hazard | (wv_q[i] & ~bus.i_req_we & (wa_q[i] == bus.i_req_addr));
  end
  assign drained         = !mem_en_q && !(|rv_q) && !(|wv_q) && count == '0;
  assign bus.o_req_ready = alive_q && state_q == S_ACTIVE && occ < 16'(FIFO_DEPTH) && !hazard;
  assign acc             = bus.i_req_valid & bus.o_req_ready;
  assign bus.o_rsp_valid = count != '0;
  assign pop             = bus.o_rsp_valid & bus.i_rsp_ready;
  assign state_d = state_q == S_ACTIVE ? (bus.i_flush ? S_DRAIN : S_ACTIVE) :
                   state_q == S_DRAIN  ? (drained ? S_IDLE : S_DRAIN) :
                   (bus.i_flush ? S_IDLE : S_ACTIVE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_ACTIVE;
      alive_q     <= 1'b0;
      idle_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rv_q        <= '0;
      wv_q        <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rb_q[i] <= '0;
      for (int i = 0; i <= WR_LATENCY; i++) wa_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= 1'b1;
      idle_q    <= drained && state_q != S_DRAIN;
      wr_done_q <= wv_q[WR_LATENCY];
      mem_en_q  <= acc;
      mem_we_q  <= acc & bus.i_req_we;
      if (acc) mem_addr_q <= bus.i_req_addr;
      if (acc) mem_wdata_q <= bus.i_req_wdata;
      rv_q[0] <= mem_en_q & ~mem_we_q;
      rb_q[0] <= bank_of(32'(mem_addr_q), ADDR_W);
      for (int i = 1; i < RD_LATENCY; i++) begin
        rv_q[i] <= rv_q[i-1];
        rb_q[i] <= rb_q[i-1];
      end
      wv_q[0] <= acc & bus.i_req_we;
      wa_q[0] <= bus.i_req_addr;
      for (int i = 1; i <= WR_LATENCY; i++) begin
        wv_q[i] <= wv_q[i-1];
        wa_q[i] <= wa_q[i-1];
      end
    end
  mem_rsp_fifo #(.W(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rv_q[RD_LATENCY-1]),
    .din_i   ({rb_q[RD_LATENCY-1], bus.i_mem_rdata}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (count)
  );
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_rsp_data  = fifo_dout[DATA_W-1:0];
  assign bus.o_rsp_bank  = fifo_dout[DATA_W+1:DATA_W];
  assign bus.o_wr_done   = wr_done_q;
  assign bus.o_idle      = idle_q;
`ifdef MPM_PERF_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (acc && !bus.i_req_we && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (acc && bus.i_req_we && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (bus.i_req_valid && !bus.o_req_ready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  assign o_rd_cnt    = rd_cnt_q;
  assign o_wr_cnt    = wr_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: scoreboard bench for two mem_port_master instances (write latency 1 and 3)
module tb_mem_port_master;
  import mem_port_pkg::*;
  typedef struct {
    rsp_t r;
    int   at;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic sel, req_valid, req_we, rsp_ready, flush;
  logic [7:0]  req_addr;
  logic [11:0] req_wdata;
  logic [11:0] mem [256];
  logic [11:0] rd0, rd1;
  logic rdy, rsp_valid, wr_done, idle;
  logic [11:0] rsp_data;
  logic [1:0]  rsp_bank;
  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;
  exp_t exp_q[$];
  int   exp_wd[$];
  exp_t me;
  int   mw;
  int n0, n1, n2;
  logic [7:0]  b2b_a [4] = '{8'h05, 8'h45, 8'h85, 8'hC5};
  logic [11:0] b2b_d [4] = '{12'hA05, 12'hA45, 12'hA85, 12'hABC};
  logic [7:0]  bp_a [6] = '{8'h01, 8'h42, 8'h83, 8'hC4, 8'h06, 8'h47};
  logic [11:0] bp_d [6] = '{12'hA01, 12'hA42, 12'hA83, 12'hAC4, 12'hA06, 12'hA47};
  logic [7:0]  fl_a [3] = '{8'h20, 8'h61, 8'hA2};
  logic [11:0] fl_d [3] = '{12'hA20, 12'hA61, 12'hAA2};
  mem_port_master_if #(.DATA_W(12), .ADDR_W(8)) b0 ();
  mem_port_master_if #(.DATA_W(12), .ADDR_W(8)) b1 ();
  mem_port_master #(.WR_LATENCY(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_port_master #(.WR_LATENCY(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign b0.i_req_valid = req_valid & ~sel;
  assign b1.i_req_valid = req_valid & sel;
  assign b0.i_req_we    = req_we;
  assign b1.i_req_we    = req_we;
  assign b0.i_req_addr  = req_addr;
  assign b1.i_req_addr  = req_addr;
  assign b0.i_req_wdata = req_wdata;
  assign b1.i_req_wdata = req_wdata;
  assign b0.i_rsp_ready = rsp_ready;
  assign b1.i_rsp_ready = rsp_ready;
  assign b0.i_flush     = flush & ~sel;
  assign b1.i_flush     = flush & sel;
  assign b0.i_mem_rdata = rd0;
  assign b1.i_mem_rdata = rd1;
  assign rdy       = sel ? b1.o_req_ready : b0.o_req_ready;
  assign rsp_valid = sel ? b1.o_rsp_valid : b0.o_rsp_valid;
  assign rsp_data  = sel ? b1.o_rsp_data  : b0.o_rsp_data;
  assign rsp_bank  = sel ? b1.o_rsp_bank  : b0.o_rsp_bank;
  assign wr_done   = sel ? b1.o_wr_done   : b0.o_wr_done;
  assign idle      = sel ? b1.o_idle      : b0.o_idle;
  // memory with one-cycle registered read, shared contents
  always @(posedge clk) begin
    if (b0.o_mem_en && b0.o_mem_we) mem[b0.o_mem_addr] = b0.o_mem_wdata;
    if (b1.o_mem_en && b1.o_mem_we) mem[b1.o_mem_addr] = b1.o_mem_wdata;
    if (b0.o_mem_en && !b0.o_mem_we) rd0 <= mem[b0.o_mem_addr];
    if (b1.o_mem_en && !b1.o_mem_we) rd1 <= mem[b1.o_mem_addr];
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        me = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(me.r.data));
        check("rsp_bank", 32'(rsp_bank), 32'(me.r.bank));
        if (me.at >= 0) check("rsp_cycle", 32'(cyc), 32'(me.at));
      end
    end
    if (wr_done) begin
      if (exp_wd.size() == 0) check("wr_done_unexpected", 32'd1, 32'd0);
      else begin
        mw = exp_wd.pop_front();
        check("wr_done_cycle", 32'(cyc), 32'(mw));
      end
    end
  end
  task automatic issue(input logic we, input logic [7:0] a, input logic [11:0] d, input int at_off, output int n);
    int   k = 0;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    n = cyc + 1;
    if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    else if (we) exp_wd.push_back(n + 1 + (sel ? 3 : 1));
    else begin
      e.r.bank = a[7:6];
      e.r.data = d;
      e.at     = at_off < 0 ? -1 : n + at_off;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int   k = 0;
    logic ok = 1'b0;
    while (!ok && k < 200) begin
      @(negedge clk);
      k++;
      ok = idle && exp_q.size() == 0 && exp_wd.size() == 0;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 12'hA00 | 12'(i);
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(b0.o_req_ready), 32'd0);
    check("rst_mem_en", 32'(b0.o_mem_en), 32'd0);
    check("rst_rsp_valid", 32'(b0.o_rsp_valid), 32'd0);
    check("rst_idle", 32'(b0.o_idle), 32'd0);
    check("rst_wr_done", 32'(b0.o_wr_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    issue(1'b1, 8'hC5, 12'hABC, -1, n0);
    wait_idle();
    issue(1'b0, 8'hC5, 12'hABC, 2, n0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, b2b_a[i], b2b_d[i], 2, n1);
      if (i > 0) check("b2b_accept", 32'(n1), 32'(n0 + 1));
      n0 = n1;
    end
    wait_idle();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, bp_a[i], bp_d[i], -1, n0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = bp_a[4];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    for (int i = 4; i < 6; i++) issue(1'b0, bp_a[i], bp_d[i], -1, n0);
    wait_idle();
    sel = 1'b1;
    issue(1'b1, 8'h10, 12'h5A5, -1, n0);
    issue(1'b0, 8'h11, 12'hA11, 2, n1);
    check("nohaz_accept", 32'(n1), 32'(n0 + 1));
    issue(1'b0, 8'h10, 12'h5A5, 2, n2);
    check("haz_accept", 32'(n2), 32'(n0 + 5));
    wait_idle();
    sel = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, fl_a[i], fl_d[i], -1, n0);
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drain_ready", 32'(rdy), 32'd0);
    check("drain_idle", 32'(idle), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    check("flush_idle", 32'(idle), 32'd1);
    check("flush_ready", 32'(rdy), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("unflush_same_cycle", 32'(rdy), 32'd0);
    @(negedge clk);
    check("unflush_ready", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    issue(1'b0, 8'h05, 12'hA05, -1, n0);
    issue(1'b0, 8'h45, 12'hA45, -1, n0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_en", 32'(b0.o_mem_en), 32'd0);
    check("midrst_ready", 32'(b0.o_req_ready), 32'd0);
    check("midrst_rsp_valid", 32'(b0.o_rsp_valid), 32'd0);
    check("midrst_idle", 32'(b0.o_idle), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("midrst_idle_after", 32'(b0.o_idle), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_stale", 32'(b0.o_rsp_valid), 32'd0);
      @(negedge clk);
    end
    check("rsp_left", 32'(exp_q.size()), 32'd0);
    check("wr_left", 32'(exp_wd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
